// File: rtl/vend_dispense_if.sv
// Vend dispense controller bus: request handshake, motor drive, drop sensor,
// coin-hopper req/ack and the transaction result.
interface vend_dispense_if #(
   parameter int NUM_SLOTS = 4,
   parameter int CREDIT_W  = 8
);
   localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

   logic                  req_valid;
   logic                  req_ready;
   logic [SLOT_W-1:0]     req_slot;
   logic [CREDIT_W-1:0]   req_credit;
   logic [CREDIT_W-1:0]   req_price;
   logic [NUM_SLOTS-1:0]  motor_en;
   logic                  drop_sense;
   logic                  coin_req;
   logic                  coin_ack;
   logic                  done;
   logic [1:0]            status;
   logic [CREDIT_W-1:0]   residue;

   // Credit FSM, sensor and hopper side
   modport master (
      output req_valid, req_slot, req_credit, req_price, drop_sense, coin_ack,
      input  req_ready, motor_en, coin_req, done, status, residue
   );

   // Dispense controller side
   modport slave (
      input  req_valid, req_slot, req_credit, req_price, drop_sense, coin_ack,
      output req_ready, motor_en, coin_req, done, status, residue
   );
endinterface

// File: rtl/vend_dispense_ctrl.sv
// Vend dispense controller: checks credit against price, pulses the slot motor,
// confirms the drop with a timeout and pays change or a refund in coins
// through the hopper req/ack handshake.
module vend_dispense_ctrl #(
   parameter int NUM_SLOTS     = 4,
   parameter int CREDIT_W      = 8,
   parameter int MOTOR_CYCLES  = 16,
   parameter int SENSE_TIMEOUT = 64,
   parameter int COIN_VALUE    = 5
) (
   input logic           clock,
   input logic           reset,
   vend_dispense_if.slave bus
);
   localparam int SLOT_W  = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
   localparam int CNT_MAX = (MOTOR_CYCLES > SENSE_TIMEOUT) ? MOTOR_CYCLES : SENSE_TIMEOUT;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   // One extra bit so the slot range check stays meaningful when NUM_SLOTS is a power of two
   localparam logic [SLOT_W:0]   SLOT_LIMIT = (SLOT_W + 1)'(NUM_SLOTS);
   localparam logic [CNT_W-1:0]  MOTOR_LAST = CNT_W'(MOTOR_CYCLES - 1);
   localparam logic [CNT_W-1:0]  SENSE_LAST = CNT_W'(SENSE_TIMEOUT - 1);
   localparam logic [CREDIT_W-1:0] COIN     = CREDIT_W'(COIN_VALUE);

   localparam logic [1:0] ST_OK      = 2'd0;
   localparam logic [1:0] ST_INSUFF  = 2'd1;
   localparam logic [1:0] ST_JAM     = 2'd2;
   localparam logic [1:0] ST_BADSLOT = 2'd3;

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      MOTOR,
      SENSE,
      CHANGE,
      DONE
   } state_t;

   state_t               state_q;
   logic [SLOT_W-1:0]    slot_q;
   logic [CREDIT_W-1:0]  credit_q;
   logic [CREDIT_W-1:0]  price_q;
   logic [CREDIT_W-1:0]  change_q;
   logic [CNT_W-1:0]     cnt_q;
   logic                 dropped_q;
   logic [NUM_SLOTS-1:0] motor_en_q;
   logic                 coin_req_q;
   logic                 done_q;
   logic [1:0]           status_q;
   logic [CREDIT_W-1:0]  residue_q;

   // Ready is combinational so a request is never accepted in the reset cycle
   assign bus.req_ready = (state_q == IDLE) && !reset;
   assign bus.motor_en  = motor_en_q;
   assign bus.coin_req  = coin_req_q;
   assign bus.done      = done_q;
   assign bus.status    = status_q;
   assign bus.residue   = residue_q;

   // Transaction sequencer; every output is registered and set on the state transition
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         slot_q     <= '0;
         credit_q   <= '0;
         price_q    <= '0;
         change_q   <= '0;
         cnt_q      <= '0;
         dropped_q  <= 1'b0;
         motor_en_q <= '0;
         coin_req_q <= 1'b0;
         done_q     <= 1'b0;
         status_q   <= ST_OK;
         residue_q  <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.req_valid) begin
                  slot_q   <= bus.req_slot;
                  credit_q <= bus.req_credit;
                  price_q  <= bus.req_price;
                  state_q  <= CHECK;
               end
            end
            CHECK: begin
               cnt_q     <= '0;
               dropped_q <= 1'b0;
               if ({1'b0, slot_q} >= SLOT_LIMIT) begin
                  change_q <= credit_q;
                  status_q <= ST_BADSLOT;
                  state_q  <= CHANGE;
               end else if (credit_q < price_q) begin
                  change_q <= credit_q;
                  status_q <= ST_INSUFF;
                  state_q  <= CHANGE;
               end else begin
                  change_q   <= credit_q - price_q;
                  status_q   <= ST_OK;
                  motor_en_q <= NUM_SLOTS'(1) << slot_q;
                  state_q    <= MOTOR;
               end
            end
            MOTOR: begin
               if (cnt_q == MOTOR_LAST) begin
                  motor_en_q <= '0;
                  cnt_q      <= '0;
                  state_q    <= (dropped_q || bus.drop_sense) ? CHANGE : SENSE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
                  if (bus.drop_sense) begin
                     dropped_q <= 1'b1;
                  end
               end
            end
            SENSE: begin
               if (bus.drop_sense) begin
                  state_q <= CHANGE;
               end else if (cnt_q == SENSE_LAST) begin
                  status_q <= ST_JAM;
                  change_q <= credit_q;
                  state_q  <= CHANGE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            CHANGE: begin
               if (coin_req_q) begin
                  if (bus.coin_ack) begin
                     change_q   <= change_q - COIN;
                     coin_req_q <= 1'b0;
                  end
               end else if (change_q >= COIN) begin
                  coin_req_q <= 1'b1;
               end else begin
                  residue_q <= change_q;
                  done_q    <= 1'b1;
                  state_q   <= DONE;
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end
endmodule
